// File: rtl/ray_frame_scheduler.sv
// Frame sequencer for the raytracer: issues (pixel, triangle) intersection jobs in raster order,
// keeps the closest hit per pixel, writes it to the pixel sink and pulses update at frame end.
module ray_frame_scheduler #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 48,
  parameter int unsigned MAX_TRIS  = 12,
  parameter int unsigned DEPTH_W   = 16,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int unsigned TW = $clog2(MAX_TRIS + 1)
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               start,
  input  logic               continuous,
  input  logic [TW-1:0]      num_tris,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [XW-1:0]      req_x,
  output logic [YW-1:0]      req_y,
  output logic [TW-1:0]      req_tri,
  input  logic               rsp_valid,
  input  logic               rsp_hit,
  input  logic [DEPTH_W-1:0] rsp_depth,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [XW-1:0]      pix_x,
  output logic [YW-1:0]      pix_y,
  output logic               pix_hit,
  output logic [TW-1:0]      pix_tri,
  output logic [DEPTH_W-1:0] pix_depth,
  output logic               busy,
  output logic               update,
  output logic               xform_step,
  output logic [15:0]        frame_count
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_FRAME_END} state_t;

  state_t             state_q;
  logic [TW-1:0]      ntri_q, tri_q, rsp_cnt_q;
  logic [XW-1:0]      x_q, pix_x_q;
  logic [YW-1:0]      y_q, pix_y_q;
  logic [OW-1:0]      outst_q, outst_d;
  logic               best_hit_q, pix_hit_q;
  logic [TW-1:0]      best_tri_q, pix_tri_q;
  logic [DEPTH_W-1:0] best_depth_q, pix_depth_q;
  logic               req_valid_q, pix_valid_q, busy_q, update_q, xform_q;
  logic [15:0]        frame_cnt_q;

  logic               req_fire, best_take, tri_last, pix_last;
  logic [TW-1:0]      ntri_clamp_d;

  assign req_fire     = req_valid_q && req_ready;
  assign best_take    = rsp_valid && rsp_hit && (!best_hit_q || (rsp_depth < best_depth_q));
  assign tri_last     = (tri_q == (ntri_q - TW'(1)));
  assign pix_last     = (x_q == X_LAST) && (y_q == Y_LAST);
  assign ntri_clamp_d = (num_tris > TW'(MAX_TRIS)) ? TW'(MAX_TRIS) : num_tris;

  // In-flight request count: a transfer and a response in the same cycle cancel out
  always_comb begin
    outst_d = outst_q;
    case ({req_fire, rsp_valid})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ntri_q       <= '0;
      tri_q        <= '0;
      rsp_cnt_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      outst_q      <= '0;
      best_hit_q   <= 1'b0;
      best_tri_q   <= '0;
      best_depth_q <= '1;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_hit_q    <= 1'b0;
      pix_tri_q    <= '0;
      pix_depth_q  <= '1;
      req_valid_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      update_q     <= 1'b0;
      xform_q      <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      update_q <= 1'b0;
      xform_q  <= 1'b0;
      outst_q  <= outst_d;

      // Responses arrive in issue order, so the response count is the triangle index
      if (rsp_valid) begin
        rsp_cnt_q <= rsp_cnt_q + TW'(1);
        if (best_take) begin
          best_hit_q   <= 1'b1;
          best_tri_q   <= rsp_cnt_q;
          best_depth_q <= rsp_depth;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            ntri_q      <= ntri_clamp_d;
            busy_q      <= 1'b1;
            req_valid_q <= (ntri_clamp_d != '0);
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ntri_q == '0) begin
            pix_x_q     <= x_q;
            pix_y_q     <= y_q;
            pix_hit_q   <= best_hit_q;
            pix_tri_q   <= best_tri_q;
            pix_depth_q <= best_depth_q;
            pix_valid_q <= 1'b1;
            state_q     <= S_WRITE;
          end else begin
            if (req_fire) tri_q <= tri_q + TW'(1);
            if (req_fire && tri_last) begin
              req_valid_q <= 1'b0;
              state_q     <= S_DRAIN;
            end else begin
              req_valid_q <= (outst_d < OUTST_MAX);
            end
          end
        end
        S_DRAIN: begin
          if (rsp_cnt_q == ntri_q) begin
            pix_x_q     <= x_q;
            pix_y_q     <= y_q;
            pix_hit_q   <= best_hit_q;
            pix_tri_q   <= best_tri_q;
            pix_depth_q <= best_depth_q;
            pix_valid_q <= 1'b1;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (pix_ready) begin
            pix_valid_q  <= 1'b0;
            tri_q        <= '0;
            rsp_cnt_q    <= '0;
            best_hit_q   <= 1'b0;
            best_tri_q   <= '0;
            best_depth_q <= '1;
            if (pix_last) begin
              x_q         <= '0;
              y_q         <= '0;
              update_q    <= 1'b1;
              xform_q     <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              state_q     <= S_FRAME_END;
            end else begin
              if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end else begin
                x_q <= x_q + XW'(1);
              end
              req_valid_q <= (ntri_q != '0) && (outst_d < OUTST_MAX);
              state_q     <= S_ISSUE;
            end
          end
        end
        S_FRAME_END: begin
          if (continuous) begin
            ntri_q      <= ntri_clamp_d;
            req_valid_q <= (ntri_clamp_d != '0);
            state_q     <= S_ISSUE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_valid   = req_valid_q;
  assign req_x       = x_q;
  assign req_y       = y_q;
  assign req_tri     = tri_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_hit     = pix_hit_q;
  assign pix_tri     = pix_tri_q;
  assign pix_depth   = pix_depth_q;
  assign busy        = busy_q;
  assign update      = update_q;
  assign xform_step  = xform_q;
  assign frame_count = frame_cnt_q;

endmodule
